// File: rtl/bsg_mcl_host_arb_pkg.sv
//------------------------------------------------------------------------------
// Module  : bsg_mcl_host_arb_pkg
// Brief   : Shared types and constants for the host request arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bsg_mcl_host_arb_pkg;

    localparam int words_per_pkt_gp = 4;
    localparam int c_stats_width    = 32;

    typedef enum logic [0:0] {
        e_arb_idle  = 1'b0,
        e_arb_burst = 1'b1
    } arb_state_e;

    // Width of an index into x items, never less than one bit.
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_mcl_rr_pick.sv
//------------------------------------------------------------------------------
// Module  : bsg_mcl_rr_pick
// Brief   : Combinational round-robin picker: first eligible index at or after
//           rr_ptr_i, wrapping modulo width_p.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_mcl_rr_pick
    import bsg_mcl_host_arb_pkg::*;
#(
    parameter int width_p = 4
) (
    input  logic [width_p-1:0]                   eligible_i,
    input  logic [safe_clog2(width_p)-1:0]       rr_ptr_i,
    output logic                                 found_o,
    output logic [safe_clog2(width_p)-1:0]       idx_o
);

    localparam int c_lg_width = safe_clog2(width_p);

    int w_k;

    // Walk offsets from farthest to nearest so the nearest eligible one wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        w_k     = 0;
        for (int i = width_p - 1; i >= 0; i--) begin
            w_k = (int'(rr_ptr_i) + i) % width_p;
            if (eligible_i[w_k]) begin
                found_o = 1'b1;
                idx_o   = w_k[c_lg_width-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bsg_mcl_host_req_arbiter.sv
//------------------------------------------------------------------------------
// Module  : bsg_mcl_host_req_arbiter
// Brief   : Packet-atomic, credit-gated round-robin arbiter sharing one host
//           request slot. Optional stats counters under BSG_MCL_ARB_STATS_EN.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bsg_mcl_host_req_arbiter
    import bsg_mcl_host_arb_pkg::*;
#(
    parameter int num_req_p         = 4,
    parameter int word_width_p      = 32,
    parameter int words_per_pkt_p   = words_per_pkt_gp,
    parameter int max_out_credits_p = 16,
    parameter int credit_thresh_p   = 1
) (
    input  logic                                   clk_i,
    input  logic                                   reset_i,
    input  logic [num_req_p-1:0]                   req_v_i,
    input  logic [num_req_p*word_width_p-1:0]      req_data_i,
    output logic [num_req_p-1:0]                   req_ready_o,
    output logic                                   fifo_v_o,
    output logic [word_width_p-1:0]                fifo_data_o,
    input  logic                                   fifo_ready_i,
    input  logic [$clog2(max_out_credits_p+1)-1:0] out_credits_i,
    output logic [safe_clog2(num_req_p)-1:0]       grant_id_o,
    output logic                                   busy_o
`ifdef BSG_MCL_ARB_STATS_EN
    ,
    output logic [num_req_p-1:0][c_stats_width-1:0] pkt_count_o,
    output logic [c_stats_width-1:0]                credit_stall_o
`endif
);

    localparam int c_lg_req  = safe_clog2(num_req_p);
    localparam int c_lg_wpk  = safe_clog2(words_per_pkt_p);
    localparam int c_cred_w  = $clog2(max_out_credits_p + 1);

    arb_state_e            r_state;
    logic [c_lg_req-1:0]   r_grant;
    logic [c_lg_req-1:0]   r_rr_ptr;
    logic [c_lg_wpk-1:0]   r_word_cnt;
    logic                  r_busy;

    logic                  w_credit_ok;
    logic [num_req_p-1:0]  w_eligible;
    logic                  w_found;
    logic [c_lg_req-1:0]   w_pick_idx;
    logic                  w_in_burst;
    logic                  w_hs;
    logic                  w_last;
    logic [c_lg_req-1:0]   w_next_ptr;

    // Credits only matter at packet start; once in BURST they are ignored.
    assign w_credit_ok = (out_credits_i >= c_cred_w'(credit_thresh_p));
    assign w_eligible  = ((r_state == e_arb_idle) && w_credit_ok) ? req_v_i : '0;

    bsg_mcl_rr_pick #(
        .width_p    (num_req_p)
    ) u_rr_pick (
        .eligible_i (w_eligible),
        .rr_ptr_i   (r_rr_ptr),
        .found_o    (w_found),
        .idx_o      (w_pick_idx)
    );

    assign w_in_burst  = (r_state == e_arb_burst);
    assign fifo_v_o    = w_in_burst & req_v_i[r_grant];
    assign fifo_data_o = w_in_burst ? req_data_i[r_grant*word_width_p +: word_width_p]
                                    : '0;

    always_comb begin
        req_ready_o = '0;
        if (w_in_burst) begin
            req_ready_o[r_grant] = fifo_ready_i;
        end
    end

    assign w_hs       = fifo_v_o & fifo_ready_i;
    assign w_last     = w_hs && (r_word_cnt == c_lg_wpk'(words_per_pkt_p - 1));
    assign w_next_ptr = (r_grant == c_lg_req'(num_req_p - 1)) ? '0
                                                              : r_grant + c_lg_req'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= e_arb_idle;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_word_cnt <= '0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                e_arb_idle: begin
                    if (w_found) begin
                        r_grant    <= w_pick_idx;
                        r_word_cnt <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= e_arb_burst;
                    end
                end
                e_arb_burst: begin
                    if (w_last) begin
                        r_state    <= e_arb_idle;
                        r_busy     <= 1'b0;
                        r_word_cnt <= '0;
                        r_rr_ptr   <= w_next_ptr;
                    end else if (w_hs) begin
                        r_word_cnt <= r_word_cnt + c_lg_wpk'(1);
                    end
                end
                default: begin
                    r_state <= e_arb_idle;
                end
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign grant_id_o = r_grant;

`ifdef BSG_MCL_ARB_STATS_EN
    logic [num_req_p-1:0][c_stats_width-1:0] r_pkt_cnt;
    logic [c_stats_width-1:0]                r_stall_cnt;
    logic                                    w_stall;

    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_pkt_cnt
        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                r_pkt_cnt[gi] <= '0;
            end else if (w_last && (r_grant == c_lg_req'(gi)) && (r_pkt_cnt[gi] != '1)) begin
                r_pkt_cnt[gi] <= r_pkt_cnt[gi] + c_stats_width'(1);
            end
        end
    end

    assign w_stall = (r_state == e_arb_idle) && (|req_v_i) && !w_credit_ok;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + c_stats_width'(1);
        end
    end

    assign pkt_count_o    = r_pkt_cnt;
    assign credit_stall_o = r_stall_cnt;
`endif

`ifndef SYNTHESIS
    for (genvar gi = 0; gi < num_req_p; gi++) begin : g_assert_stable
        a_data_stable: assert property (@(posedge clk_i) disable iff (reset_i)
            (req_v_i[gi] && !req_ready_o[gi]) ##1 req_v_i[gi]
            |-> $stable(req_data_i[gi*word_width_p +: word_width_p]));
    end

    a_grant_range: assert property (@(posedge clk_i) disable iff (reset_i)
        int'(r_grant) < num_req_p);
`endif

endmodule

`default_nettype wire

// File: tb/tb_bsg_mcl_host_req_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_bsg_mcl_host_req_arbiter
// Brief   : Scoreboard bench for bsg_mcl_host_req_arbiter.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bsg_mcl_host_req_arbiter;

    localparam int c_n   = 4;
    localparam int c_w   = 32;
    localparam int c_wpk = 4;

    logic               clk = 1'b0;
    logic               reset_i;
    logic [c_n-1:0]     req_v_i;
    logic [c_n*c_w-1:0] req_data_i;
    logic [c_n-1:0]     req_ready_o;
    logic               fifo_v_o;
    logic [c_w-1:0]     fifo_data_o;
    logic               fifo_ready_i;
    logic [4:0]         out_credits_i;
    logic [1:0]         grant_id_o;
    logic               busy_o;
`ifdef BSG_MCL_ARB_STATS_EN
    logic [c_n-1:0][31:0] pkt_count_o;
    logic [31:0]          credit_stall_o;
`endif

    bsg_mcl_host_req_arbiter #(
        .num_req_p         (c_n),
        .word_width_p      (c_w),
        .words_per_pkt_p   (c_wpk),
        .max_out_credits_p (16),
        .credit_thresh_p   (1)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset_i),
        .req_v_i        (req_v_i),
        .req_data_i     (req_data_i),
        .req_ready_o    (req_ready_o),
        .fifo_v_o       (fifo_v_o),
        .fifo_data_o    (fifo_data_o),
        .fifo_ready_i   (fifo_ready_i),
        .out_credits_i  (out_credits_i),
        .grant_id_o     (grant_id_o),
        .busy_o         (busy_o)
`ifdef BSG_MCL_ARB_STATS_EN
        ,
        .pkt_count_o    (pkt_count_o),
        .credit_stall_o (credit_stall_o)
`endif
    );

    always #5 clk = ~clk;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] src_mem [c_n][16];
    int          src_wr  [c_n];
    int          src_rd  [c_n];
    logic [c_n-1:0] gap;
    logic [33:0] exp_q [$];
    int          hs_cnt   = 0;
    int          busy_cnt = 0;
    logic        last_busy;
    logic        last_fifo_v;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < c_n; i++) begin
            if (src_rd[i] < src_wr[i]) begin
                req_v_i[i]                = ~gap[i];
                req_data_i[i*c_w +: c_w]  = src_mem[i][src_rd[i] % 16];
            end else begin
                req_v_i[i]                = 1'b0;
                req_data_i[i*c_w +: c_w]  = '0;
            end
        end
    endtask

    // Queue one packet on requester r and record its words as the next expected output.
    task automatic load_pkt(input int r, input int tag);
        logic [1:0]  rid;
        logic [31:0] val;
        rid = r[1:0];
        for (int w = 0; w < c_wpk; w++) begin
            val = 32'((r << 24) | (tag << 8) | w);
            src_mem[r][src_wr[r] % 16] = val;
            src_wr[r]++;
            exp_q.push_back({rid, val});
        end
        drive();
    endtask

    // One clock: sample at negedge, consume accepted words after the posedge.
    task automatic step();
        logic [c_n-1:0] acc;
        logic [c_n-1:0] rdy_exp;
        logic [33:0]    e;
        @(negedge clk);
        acc         = req_v_i & req_ready_o;
        last_busy   = busy_o;
        last_fifo_v = fifo_v_o;
        if (busy_o) busy_cnt++;
        rdy_exp = busy_o ? (c_n'(fifo_ready_i) << grant_id_o) : '0;
        chk_eq("req_ready", 64'(req_ready_o), 64'(rdy_exp));
        chk_eq("fifo_v", 64'(fifo_v_o), busy_o ? 64'(req_v_i[grant_id_o]) : 64'd0);
        if (fifo_v_o && fifo_ready_i) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_word", 64'({grant_id_o, fifo_data_o}), 64'h0);
            end else begin
                e = exp_q.pop_front();
                chk_eq("word", 64'({grant_id_o, fifo_data_o}), 64'(e));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < c_n; i++) begin
            if (acc[i]) src_rd[i]++;
        end
        drive();
    endtask

    task automatic drain(input int budget, output int n);
        n = 0;
        while ((exp_q.size() != 0 || busy_o) && n < budget) begin
            step();
            n++;
        end
        chk_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        for (int i = 0; i < c_n; i++) src_rd[i] = src_wr[i];
        exp_q.delete();
        drive();
        step();
        step();
        reset_i = 1'b0;
    endtask

    initial begin
        int n;
        int h0;
        reset_i       = 1'b1;
        req_v_i       = '0;
        req_data_i    = '0;
        fifo_ready_i  = 1'b1;
        out_credits_i = 5'd16;
        gap           = '0;
        for (int i = 0; i < c_n; i++) begin
            src_wr[i] = 0;
            src_rd[i] = 0;
        end
        #3;
        chk_eq("rst_busy",  64'(busy_o),      64'd0);
        chk_eq("rst_grant", 64'(grant_id_o),  64'd0);
        chk_eq("rst_fifo_v", 64'(fifo_v_o),   64'd0);
        chk_eq("rst_ready", 64'(req_ready_o), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b0;

        // Contention: order 0,1,2,3,0 with one idle cycle per packet.
        load_pkt(0, 1); load_pkt(1, 1); load_pkt(2, 1); load_pkt(3, 1); load_pkt(0, 2);
        busy_cnt = 0;
        drain(100, n);
        chk_eq("cont_cycles", 64'(n), 64'd25);
        chk_eq("cont_busy", 64'(busy_cnt), 64'd20);

        // Single requester 2: rr_ptr is 1 here.
        load_pkt(2, 3);
        step();
        chk_eq("single_lat_v", 64'(last_fifo_v), 64'd0);
        chk_eq("single_lat_busy", 64'(last_busy), 64'd0);
        step();
        chk_eq("single_first_busy", 64'(last_busy), 64'd1);
        drain(20, n);
        chk_eq("single_tail", 64'(n), 64'd3);
        chk_eq("single_grant_hold", 64'(grant_id_o), 64'd2);
        // rr_ptr should now be 3, so 3 beats 0.
        load_pkt(3, 4); load_pkt(0, 4);
        drain(40, n);
        chk_eq("ptr3_cycles", 64'(n), 64'd10);

        // Credit gate on requester 1 (rr_ptr now 1).
        out_credits_i = 5'd0;
        load_pkt(1, 5);
        busy_cnt = 0;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (last_fifo_v) n++;
        end
        chk_eq("cg_no_v", 64'(n), 64'd0);
        chk_eq("cg_no_busy", 64'(busy_cnt), 64'd0);
        out_credits_i = 5'd1;
        step();
        chk_eq("cg_idle_cycle", 64'(last_busy), 64'd0);
        step();
        chk_eq("cg_start", 64'(last_busy), 64'd1);
        out_credits_i = 5'd0;
        h0 = hs_cnt - 1;
        drain(20, n);
        chk_eq("cg_words", 64'(hs_cnt - h0), 64'd4);
        out_credits_i = 5'd16;

        // Backpressure and a bubble from requester 3, then requester 0.
        load_pkt(3, 6); load_pkt(0, 6);
        h0 = hs_cnt;
        n  = 0;
        while ((exp_q.size() != 0 || busy_o) && n < 80) begin
            fifo_ready_i = n[0];
            gap[3]       = (n >= 4 && n < 8);
            drive();
            step();
            n++;
        end
        fifo_ready_i = 1'b1;
        gap          = '0;
        drive();
        chk_eq("bp_drain", 64'(exp_q.size()), 64'd0);
        chk_eq("bp_words", 64'(hs_cnt - h0), 64'd8);

        // Async reset after two words of a packet from requester 1 (rr_ptr 1).
        load_pkt(1, 7);
        h0 = hs_cnt;
        n  = 0;
        while (hs_cnt < h0 + 2 && n < 20) begin
            step();
            n++;
        end
        chk_eq("ar_two_words", 64'(hs_cnt - h0), 64'd2);
        chk_eq("ar_busy_before", 64'(busy_o), 64'd1);
        #1;
        reset_i = 1'b1;
        #1;
        chk_eq("ar_busy",   64'(busy_o),      64'd0);
        chk_eq("ar_grant",  64'(grant_id_o),  64'd0);
        chk_eq("ar_fifo_v", 64'(fifo_v_o),    64'd0);
        chk_eq("ar_data",   64'(fifo_data_o), 64'd0);
        chk_eq("ar_ready",  64'(req_ready_o), 64'd0);
        chk_eq("ar_partial", 64'(exp_q.size()), 64'd2);
        @(posedge clk);
        #1;
        do_reset();
        // rr_ptr back at 0, so 0 precedes 3.
        load_pkt(0, 8); load_pkt(3, 8);
        drain(40, n);
        chk_eq("ar_next_cycles", 64'(n), 64'd10);

`ifdef BSG_MCL_ARB_STATS_EN
        do_reset();
        out_credits_i = 5'd0;
        load_pkt(3, 9);
        for (int k = 0; k < 5; k++) step();
        out_credits_i = 5'd16;
        drain(20, n);
        load_pkt(0, 9); load_pkt(0, 10); load_pkt(0, 11);
        drain(60, n);
        chk_eq("st_pkt0", 64'(pkt_count_o[0]), 64'd3);
        chk_eq("st_pkt1", 64'(pkt_count_o[1]), 64'd0);
        chk_eq("st_pkt2", 64'(pkt_count_o[2]), 64'd0);
        chk_eq("st_pkt3", 64'(pkt_count_o[3]), 64'd1);
        chk_eq("st_stall", 64'(credit_stall_o), 64'd5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
